pwm_guard_multi: RTL

Parametrised multi-channel successor to the single-channel PWM/stop export path of the Nios security subsystem. It generates NCH PWM outputs on one shared period counter, with per-channel duty taken either from software registers or from pulse widths measured on the matching PWM input. A per-channel loss-of-signal watchdog substitutes a failsafe duty when an input goes silent. It sits between the Nios PIO exports (period/duty/stop) and the actuator pins.

---
 rtl/pwm_guard_multi_if.sv | 30 +++
 rtl/pwm_guard_multi.sv | 106 ++++++++++
 2 files changed

// File: rtl/pwm_guard_multi_if.sv
`default_nettype none
// ============================================================================
// pwm_guard_multi_if : register/pin bundle between Nios PIO exports, the
// PWM guard and the actuator pins.  Rev 1.0
// ============================================================================
interface pwm_guard_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32
);
  logic [CNT_W-1:0]     period;
  logic [NCH*CNT_W-1:0] duty;
  logic [NCH-1:0]       src_sel;
  logic                 stop;
  logic [NCH-1:0]       pwm_in;
  logic [NCH-1:0]       pwm_out;
  logic [NCH*CNT_W-1:0] meas_high;
  logic [NCH-1:0]       meas_valid;
  logic [NCH-1:0]       lost;

  modport master (
    output period, duty, src_sel, stop, pwm_in,
    input  pwm_out, meas_high, meas_valid, lost
  );

  modport slave (
    input  period, duty, src_sel, stop, pwm_in,
    output pwm_out, meas_high, meas_valid, lost
  );
endinterface
`default_nettype wire

// File: rtl/pwm_guard_multi.sv
`default_nettype none
// ============================================================================
// pwm_guard_multi : NCH-channel PWM on a shared period counter, with input
// pulse-width capture and loss-of-signal failsafe duty.  Rev 1.0
// ============================================================================
module pwm_guard_multi #(
  parameter int NCH           = 4,
  parameter int CNT_W         = 32,
  parameter int TIMEOUT       = 1000000,
  parameter int FAILSAFE_DUTY = 0
) (
  input  wire logic        clk_clk,
  input  wire logic        reset_reset_n,
  pwm_guard_multi_if.slave bus
);
  localparam int                IDLE_W     = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] C_TIMEOUT  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] C_IDLE_SET = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  C_FAILSAFE = CNT_W'(FAILSAFE_DUTY);

  logic [CNT_W-1:0] cnt_q, cnt_d, period_sh_q;
  logic             stop_q;
  logic             short_per, wrap, load, run;

  // stop_q marks the release cycle: shadows reload there and outputs stay low
  always_comb begin
    short_per = (period_sh_q < CNT_W'(2));
    wrap      = !bus.stop && !short_per && (cnt_q == period_sh_q - CNT_W'(1));
    load      = short_per || (!bus.stop && (stop_q || wrap));
    run       = !bus.stop && !stop_q && !short_per;
    cnt_d     = (run && !wrap) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q       <= '0;
      period_sh_q <= '0;
      stop_q      <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      stop_q <= bus.stop;
      if (load) period_sh_q <= bus.period;
    end
  end

  logic [NCH-1:0]       pwm_out_w, meas_valid_w, lost_w;
  logic [NCH*CNT_W-1:0] meas_high_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [2:0]        sync_q;
    logic [CNT_W-1:0]  duty_sh_q, hcnt_q, meas_q, duty_eff;
    logic [IDLE_W-1:0] idle_q;
    logic              armed_q, valid_q, lost_q, out_q;
    logic              rise, fall;

    always_comb begin
      rise     = sync_q[1] & ~sync_q[2];
      fall     = ~sync_q[1] & sync_q[2];
      duty_eff = bus.duty[i*CNT_W +: CNT_W];
      if (bus.src_sel[i]) duty_eff = lost_q ? C_FAILSAFE : meas_q;
    end

    // sync_q[1:0] is the synchroniser, sync_q[2] the edge-detect history
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        sync_q    <= '0;
        duty_sh_q <= '0;
        hcnt_q    <= '0;
        meas_q    <= '0;
        idle_q    <= '0;
        armed_q   <= 1'b0;
        valid_q   <= 1'b0;
        lost_q    <= 1'b1;
        out_q     <= 1'b0;
      end else begin
        sync_q  <= {sync_q[1:0], bus.pwm_in[i]};
        out_q   <= run && (cnt_q < duty_sh_q);
        valid_q <= fall && armed_q;
        if (load) duty_sh_q <= duty_eff;

        if (rise)                           hcnt_q <= CNT_W'(1);
        else if (sync_q[1] && hcnt_q != '1) hcnt_q <= hcnt_q + CNT_W'(1);

        if (rise)              armed_q <= 1'b1;
        if (fall && armed_q)   meas_q  <= hcnt_q;

        if (rise)                     idle_q <= '0;
        else if (idle_q != C_TIMEOUT) idle_q <= idle_q + IDLE_W'(1);

        if (!rise && idle_q == C_IDLE_SET) lost_q <= 1'b1;
        else if (fall && armed_q)          lost_q <= 1'b0;
      end
    end

    assign pwm_out_w[i]                  = out_q;
    assign meas_valid_w[i]               = valid_q;
    assign lost_w[i]                     = lost_q;
    assign meas_high_w[i*CNT_W +: CNT_W] = meas_q;
  end

  assign bus.pwm_out    = pwm_out_w;
  assign bus.meas_valid = meas_valid_w;
  assign bus.lost       = lost_w;
  assign bus.meas_high  = meas_high_w;
endmodule
`default_nettype wire
